// File: rtl/stack_exec.sv
// -----------------------------------------------------------------------------
// stack_exec
//   Execution sequencer sitting directly upstream of the CPU operand stack.
//   Takes one stack-machine operation at a time (valid/ready), steps it through
//   FETCH -> WAIT -> CHECK -> EXEC and drives the stack's push / pop-count /
//   read-offset / write-data controls for exactly one EXEC cycle per op.
//   A shadow depth counter traps underflow, overflow and illegal opcodes; any
//   trap parks the sequencer in HALT until reset.
//
// Ports
//   clk, rst_b           clock, asynchronous active-low reset
//   op_valid/op_ready    operation handshake; op_code, op_imm carry the op
//   st__push             stack push enable (pushes pre-increment sp)
//   st__to_pop           entries popped this cycle
//   st__top_n_offset     read offset for st__top_n
//   st__to_push          push data
//   st__top_0/top_n      registered stack[sp] / stack[sp-offset] from the stack
//   out_valid/out_ready  popped-value handshake; out_data is the value
//   depth                shadow entry count
//   halted, err_code     sticky trap flag and cause (1 under, 2 over, 3 illegal)
// -----------------------------------------------------------------------------
module stack_exec #(
    parameter int W         = 35,
    parameter int AW        = 11,
    parameter int DEPTH_MAX = 2047
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [3:0]    op_code,
    input  logic [W-1:0]  op_imm,
    output logic          st__push,
    output logic [AW-1:0] st__to_pop,
    output logic [AW-1:0] st__top_n_offset,
    output logic [W-1:0]  st__to_push,
    input  logic [W-1:0]  st__top_0,
    input  logic [W-1:0]  st__top_n,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [AW:0]   depth,
    output logic          halted,
    output logic [1:0]    err_code
);

    typedef enum logic [2:0] {S_FETCH, S_WAIT, S_CHECK, S_EXEC, S_HALT} state_t;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_PUSHI = 4'd1;
    localparam logic [3:0] OP_POP   = 4'd2;
    localparam logic [3:0] OP_DUP   = 4'd3;
    localparam logic [3:0] OP_ADD   = 4'd4;
    localparam logic [3:0] OP_SUB   = 4'd5;
    localparam logic [3:0] OP_AND   = 4'd6;
    localparam logic [3:0] OP_OR    = 4'd7;
    localparam logic [3:0] OP_XOR   = 4'd8;
    localparam logic [3:0] OP_OUT   = 4'd9;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_UNDER   = 2'd1;
    localparam logic [1:0] ERR_OVER    = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL = 2'd3;

    localparam logic [AW:0] DEPTH_FULL = (AW+1)'(DEPTH_MAX);

    state_t         r_state;
    state_t         w_next_state;
    logic [3:0]     r_op;
    logic [W-1:0]   r_imm;
    logic [AW:0]    r_depth;
    logic           r_halted;
    logic [1:0]     r_err;

    logic [AW-1:0]  w_n;
    logic           w_is_bin;
    logic           w_net_push;
    logic [AW:0]    w_need;
    logic [1:0]     w_chk_err;
    logic [AW-1:0]  w_offset;
    logic [W-1:0]   w_alu;
    logic [AW:0]    w_depth_next;

    assign w_n      = r_imm[AW-1:0];
    assign w_is_bin = (r_op >= OP_ADD) && (r_op <= OP_XOR);

    // Entries each op needs on the stack, and whether it grows the stack.
    // NOTE: every combinational output gets a default first, so no path through
    // the case statements leaves a signal unassigned and infers a latch.
    always_comb begin
        w_need     = '0;
        w_net_push = 1'b0;
        case (r_op)
            OP_PUSHI: w_net_push = 1'b1;
            OP_POP:   w_need = {1'b0, w_n};
            OP_DUP: begin
                w_need     = {1'b0, w_n} + (AW+1)'(1);
                w_net_push = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: w_need = (AW+1)'(2);
            OP_OUT:   w_need = (AW+1)'(1);
            default:  ;
        endcase

        // Priority: illegal opcode, then underflow, then overflow.
        if (r_op > OP_OUT)
            w_chk_err = ERR_ILLEGAL;
        else if (w_need > r_depth)
            w_chk_err = ERR_UNDER;
        else if (w_net_push && (r_depth == DEPTH_FULL))
            w_chk_err = ERR_OVER;
        else
            w_chk_err = ERR_NONE;
    end

    // Read offset: binary ops need the entry just below top; DUP needs n below.
    always_comb begin
        if (w_is_bin)
            w_offset = AW'(1);
        else if (r_op == OP_DUP)
            w_offset = w_n;
        else
            w_offset = '0;
    end

    // Second operand is st__top_n (one below top), first is st__top_0.
    always_comb begin
        case (r_op)
            OP_ADD:  w_alu = st__top_n + st__top_0;
            OP_SUB:  w_alu = st__top_n - st__top_0;
            OP_AND:  w_alu = st__top_n & st__top_0;
            OP_OR:   w_alu = st__top_n | st__top_0;
            OP_XOR:  w_alu = st__top_n ^ st__top_0;
            default: w_alu = '0;
        endcase
    end

    always_comb begin
        w_next_state     = r_state;
        op_ready         = 1'b0;
        st__push         = 1'b0;
        st__to_pop       = '0;
        st__top_n_offset = '0;
        st__to_push      = '0;
        out_valid        = 1'b0;
        out_data         = '0;
        case (r_state)
            S_FETCH: begin
                op_ready = 1'b1;
                if (op_valid)
                    w_next_state = S_WAIT;
            end
            // The stack registers its read data at the edge ending WAIT, so the
            // offset must already be valid here and held through EXEC.
            S_WAIT: begin
                st__top_n_offset = w_offset;
                w_next_state     = S_CHECK;
            end
            S_CHECK: begin
                st__top_n_offset = w_offset;
                w_next_state     = (w_chk_err != ERR_NONE) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                st__top_n_offset = w_offset;
                w_next_state     = S_FETCH;
                case (r_op)
                    OP_PUSHI: begin
                        st__push    = 1'b1;
                        st__to_push = r_imm;
                    end
                    OP_POP:   st__to_pop = w_n;
                    OP_DUP: begin
                        st__push    = 1'b1;
                        st__to_push = st__top_n;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        st__push    = 1'b1;
                        st__to_pop  = AW'(2);
                        st__to_push = w_alu;
                    end
                    // sp does not move while stalled, so st__top_0 stays stable.
                    OP_OUT: begin
                        out_valid = 1'b1;
                        out_data  = st__top_0;
                        if (out_ready)
                            st__to_pop = AW'(1);
                        else
                            w_next_state = S_EXEC;
                    end
                    default: ;
                endcase
            end
            S_HALT:  w_next_state = S_HALT;
            default: w_next_state = S_FETCH;
        endcase
    end

    // Controls are zero outside EXEC, so this is only meaningful there.
    assign w_depth_next = r_depth + (AW+1)'(st__push) - {1'b0, st__to_pop};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state  <= S_FETCH;
            r_op     <= OP_NOP;
            r_imm    <= '0;
            r_depth  <= '0;
            r_halted <= 1'b0;
            r_err    <= ERR_NONE;
        end else begin
            r_state <= w_next_state;
            if ((r_state == S_FETCH) && op_valid) begin
                r_op  <= op_code;
                r_imm <= op_imm;
            end
            if ((r_state == S_CHECK) && (w_chk_err != ERR_NONE)) begin
                r_halted <= 1'b1;
                r_err    <= w_chk_err;
            end
            if (r_state == S_EXEC)
                r_depth <= w_depth_next;
        end
    end

    assign depth    = r_depth;
    assign halted   = r_halted;
    assign err_code = r_err;

endmodule

// File: tb/tb_stack_exec.sv
// -----------------------------------------------------------------------------
// tb_stack_exec
//   Directed bench for stack_exec. A behavioural operand stack (pre-increment
//   push, registered top_0/top_n reads) closes the loop around the DUT.
// -----------------------------------------------------------------------------
module tb_stack_exec;

    localparam int W  = 35;
    localparam int AW = 11;
    localparam int DEPTH_MAX = 2047;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          op_valid;
    logic          op_ready;
    logic [3:0]    op_code;
    logic [W-1:0]  op_imm;
    logic          st__push;
    logic [AW-1:0] st__to_pop;
    logic [AW-1:0] st__top_n_offset;
    logic [W-1:0]  st__to_push;
    logic [W-1:0]  st__top_0;
    logic [W-1:0]  st__top_n;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [AW:0]   depth;
    logic          halted;
    logic [1:0]    err_code;

    int checks = 0;
    int errors = 0;

    stack_exec #(.W(W), .AW(AW), .DEPTH_MAX(DEPTH_MAX)) dut (
        .clk              (clk),
        .rst_b            (rst_b),
        .op_valid         (op_valid),
        .op_ready         (op_ready),
        .op_code          (op_code),
        .op_imm           (op_imm),
        .st__push         (st__push),
        .st__to_pop       (st__to_pop),
        .st__top_n_offset (st__top_n_offset),
        .st__to_push      (st__to_push),
        .st__top_0        (st__top_0),
        .st__top_n        (st__top_n),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .depth            (depth),
        .halted           (halted),
        .err_code         (err_code)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural stack + event recorder ----------------
    logic [W-1:0]  mem [0:(1<<AW)-1];
    logic [AW-1:0] m_sp;
    logic [AW-1:0] m_nsp;
    logic [W-1:0]  last_out;
    int            n_push = 0;
    int            n_pop  = 0;
    int            n_out  = 0;
    int            wr_q[$];

    initial begin
        for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
        last_out = '0;
    end

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            m_sp      <= '0;
            st__top_0 <= '0;
            st__top_n <= '0;
        end else begin
            st__top_0 <= mem[m_sp];
            st__top_n <= mem[m_sp - st__top_n_offset];
            m_nsp = m_sp - st__to_pop + AW'(st__push);
            if (st__push) begin
                mem[m_nsp] <= st__to_push;
                wr_q.push_back(int'(m_nsp));
                n_push++;
            end
            if (st__to_pop != '0) n_pop++;
            if (out_valid && out_ready) begin
                last_out <= out_data;
                n_out++;
            end
            m_sp <= m_nsp;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    // Called at a negedge; waits (bounded) until op_ready is seen high.
    task automatic wait_ready(input string name);
        int k = 0;
        while (!op_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!op_ready) begin
            errors++;
            $display("FAIL %s: op_ready got %0b after %0d cycles, required 1", name, op_ready, k);
        end
    endtask

    task automatic do_op(input logic [3:0] code, input logic [W-1:0] imm);
        @(negedge clk);
        wait_ready("handshake");
        op_valid = 1'b1;
        op_code  = code;
        op_imm   = imm;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] code, input logic [W-1:0] imm);
        do_op(code, imm);
        @(negedge clk);
        wait_ready("op_complete");
    endtask

    task automatic wait_halt(input string name);
        int k = 0;
        @(negedge clk);
        while (!halted && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!halted) begin
            errors++;
            $display("FAIL %s: halted got 0, required 1", name);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_b     = 1'b0;
        op_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        checks++;
        if (depth !== '0 || halted !== 1'b0 || err_code !== 2'd0) begin
            errors++;
            $display("FAIL reset_regs: depth=%0d halted=%0b err=%0d, required 0 0 0", depth, halted, err_code);
        end
        checks++;
        if (op_ready !== 1'b1 || out_valid !== 1'b0 || st__push !== 1'b0 ||
            st__to_pop !== '0 || st__top_n_offset !== '0) begin
            errors++;
            $display("FAIL reset_outs: ready=%0b oval=%0b push=%0b pop=%0d off=%0d, required 1 0 0 0 0",
                     op_ready, out_valid, st__push, st__to_pop, st__top_n_offset);
        end
    endtask

    task automatic test_sub();
        int exp_d[4] = '{1, 2, 1, 0};
        wr_q.delete();
        run_op(4'd1, 35'd5);
        checks++; if (depth !== 12'(exp_d[0])) begin errors++; $display("FAIL sub_depth0: got %0d, required %0d", depth, exp_d[0]); end
        run_op(4'd1, 35'd3);
        checks++; if (depth !== 12'(exp_d[1])) begin errors++; $display("FAIL sub_depth1: got %0d, required %0d", depth, exp_d[1]); end
        run_op(4'd5, 35'd0);
        checks++; if (depth !== 12'(exp_d[2])) begin errors++; $display("FAIL sub_depth2: got %0d, required %0d", depth, exp_d[2]); end
        run_op(4'd9, 35'd0);
        checks++; if (depth !== 12'(exp_d[3])) begin errors++; $display("FAIL sub_depth3: got %0d, required %0d", depth, exp_d[3]); end
        checks++;
        if (last_out !== 35'd2) begin
            errors++;
            $display("FAIL sub_out: got %0d, required 2", last_out);
        end
        checks++;
        if (wr_q.size() != 3 || wr_q[0] != 1 || wr_q[1] != 2 || wr_q[2] != 1) begin
            errors++;
            $display("FAIL sub_write_sp: got %p, required '{1,2,1}", wr_q);
        end
    endtask

    task automatic test_add_wrap();
        run_op(4'd1, 35'h7_FFFF_FFFF);
        run_op(4'd1, 35'd1);
        run_op(4'd4, 35'd0);
        run_op(4'd9, 35'd0);
        checks++;
        if (last_out !== 35'd0 || depth !== '0) begin
            errors++;
            $display("FAIL add_wrap: out=%0h depth=%0d, required 0 0", last_out, depth);
        end
    endtask

    task automatic test_logic_ops();
        run_op(4'd1, 35'h0F0);
        run_op(4'd1, 35'h0FF);
        run_op(4'd8, 35'd0);   // XOR -> 0x0F
        run_op(4'd1, 35'h030);
        run_op(4'd7, 35'd0);   // OR  -> 0x3F
        run_op(4'd1, 35'h01C);
        run_op(4'd6, 35'd0);   // AND -> 0x1C
        run_op(4'd0, 35'd0);   // NOP
        checks++;
        if (depth !== 12'd1) begin
            errors++;
            $display("FAIL logic_depth: got %0d, required 1", depth);
        end
        run_op(4'd9, 35'd0);
        checks++;
        if (last_out !== 35'h01C) begin
            errors++;
            $display("FAIL logic_out: got %0h, required 1c", last_out);
        end
    endtask

    task automatic test_dup_pop();
        run_op(4'd1, 35'd10);
        run_op(4'd1, 35'd20);
        run_op(4'd1, 35'd30);
        run_op(4'd3, 35'd2);
        run_op(4'd9, 35'd0);
        checks++;
        if (last_out !== 35'd10 || depth !== 12'd3) begin
            errors++;
            $display("FAIL dup_out: out=%0d depth=%0d, required 10 3", last_out, depth);
        end
        run_op(4'd2, 35'd0);   // POP 0 is a legal no-op
        checks++;
        if (depth !== 12'd3 || halted !== 1'b0) begin
            errors++;
            $display("FAIL pop0: depth=%0d halted=%0b, required 3 0", depth, halted);
        end
        run_op(4'd2, 35'd3);
        checks++;
        if (depth !== 12'd0) begin
            errors++;
            $display("FAIL pop3: depth=%0d, required 0", depth);
        end
    endtask

    task automatic test_back_pressure();
        int k = 0;
        int pops0;
        run_op(4'd1, 35'd42);
        out_ready = 1'b0;
        do_op(4'd9, 35'd0);
        @(negedge clk);
        while (!out_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        pops0 = n_pop;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 35'd42) begin
                errors++;
                $display("FAIL stall_%0d: oval=%0b data=%0d, required 1 42", i, out_valid, out_data);
            end
            @(negedge clk);
        end
        checks++;
        if (n_pop != pops0) begin
            errors++;
            $display("FAIL stall_nopop: pops=%0d, required %0d", n_pop, pops0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (op_ready !== 1'b1 || n_pop != pops0 + 1 || last_out !== 35'd42 || depth !== '0) begin
            errors++;
            $display("FAIL release: ready=%0b pops=%0d out=%0d depth=%0d, required 1 %0d 42 0",
                     op_ready, n_pop, last_out, depth, pops0 + 1);
        end
    endtask

    task automatic test_errors();
        int push0;
        int pop0;
        // ADD on empty stack: underflow, stack untouched
        apply_reset();
        push0 = n_push;
        pop0  = n_pop;
        do_op(4'd4, 35'd0);
        wait_halt("under_add");
        repeat (4) @(negedge clk);
        checks++;
        if (err_code !== 2'd1 || op_ready !== 1'b0 || n_push != push0 || n_pop != pop0) begin
            errors++;
            $display("FAIL under_add: err=%0d ready=%0b pushes=%0d pops=%0d, required 1 0 %0d %0d",
                     err_code, op_ready, n_push, n_pop, push0, pop0);
        end
        // Illegal opcode on empty stack: illegal wins over underflow
        apply_reset();
        do_op(4'd12, 35'd0);
        wait_halt("illegal");
        checks++;
        if (err_code !== 2'd3 || halted !== 1'b1) begin
            errors++;
            $display("FAIL illegal: err=%0d halted=%0b, required 3 1", err_code, halted);
        end
        // DUP with n >= depth is underflow
        apply_reset();
        run_op(4'd1, 35'd1);
        do_op(4'd3, 35'd1);
        wait_halt("under_dup");
        checks++;
        if (err_code !== 2'd1 || depth !== 12'd1) begin
            errors++;
            $display("FAIL under_dup: err=%0d depth=%0d, required 1 1", err_code, depth);
        end
        // POP more than depth
        apply_reset();
        run_op(4'd1, 35'd1);
        do_op(4'd2, 35'd2);
        wait_halt("under_pop");
        checks++;
        if (err_code !== 2'd1 || depth !== 12'd1) begin
            errors++;
            $display("FAIL under_pop: err=%0d depth=%0d, required 1 1", err_code, depth);
        end
    endtask

    task automatic test_overflow();
        int push0;
        apply_reset();
        for (int i = 0; i < DEPTH_MAX; i++)
            run_op(4'd1, 35'(i));
        checks++;
        if (depth !== 12'(DEPTH_MAX)) begin
            errors++;
            $display("FAIL full_depth: got %0d, required %0d", depth, DEPTH_MAX);
        end
        push0 = n_push;
        do_op(4'd1, 35'd99);
        wait_halt("overflow");
        checks++;
        if (err_code !== 2'd2 || depth !== 12'(DEPTH_MAX) || n_push != push0) begin
            errors++;
            $display("FAIL overflow: err=%0d depth=%0d pushes=%0d, required 2 %0d %0d",
                     err_code, depth, n_push, DEPTH_MAX, push0);
        end
    endtask

    task automatic test_reset_mid_op();
        int push0;
        apply_reset();
        push0 = n_push;
        do_op(4'd1, 35'd7);
        @(negedge clk);
        checks++;
        if (op_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_wait: op_ready=%0b, required 0", op_ready);
        end
        rst_b = 1'b0;
        #1;
        checks++;
        if (op_ready !== 1'b1 || depth !== '0) begin
            errors++;
            $display("FAIL mid_reset: ready=%0b depth=%0d, required 1 0", op_ready, depth);
        end
        @(negedge clk);
        rst_b = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (n_push != push0 || depth !== '0 || op_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_after: pushes=%0d depth=%0d ready=%0b, required %0d 0 1",
                     n_push, depth, op_ready, push0);
        end
    endtask

    initial begin
        rst_b     = 1'b0;
        op_valid  = 1'b0;
        op_code   = '0;
        op_imm    = '0;
        out_ready = 1'b1;
        test_reset();
        test_sub();
        test_add_wrap();
        test_logic_ops();
        test_dup_pop();
        test_back_pressure();
        test_errors();
        test_overflow();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
